// File: rtl/dtree_pkg.sv
// Shared definitions between the feature streamer and the decision-tree classifier:
// feature count, sample width and the streaming FSM encoding.
package dtree_pkg;

  localparam int FEATURES  = 3;
  localparam int IN_WIDTH  = 10;
  localparam int IDX_WIDTH = $clog2(FEATURES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/feature_streamer_vector_fifo.sv
// Small vector FIFO with a registered head word; holds whole packed feature vectors.
module vector_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_next = rd_ptr + 1'b1;

  // NOTE: storage is not reset; only pointers and count define validity, which keeps the array plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_next;

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // Head tracks whatever entry will sit at rd_ptr after this edge.
      if (push_ok && (empty || (pop_ok && count == CNT_ONE))) begin
        dout <= din;
      end else if (pop_ok && count > CNT_ONE) begin
        dout <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/feature_streamer.sv
// Buffers packed feature vectors and serializes them, one feature per handshake,
// into the classifier sample port; a classifier result retires the vector in service.
module feature_streamer
  import dtree_pkg::state_t, dtree_pkg::IDLE, dtree_pkg::STREAM, dtree_pkg::WAIT_DONE;
#(
  parameter int FEATURES = dtree_pkg::FEATURES,
  parameter int IN_WIDTH = dtree_pkg::IN_WIDTH,
  parameter int DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vec_valid,
  output logic                          vec_ready,
  input  logic [FEATURES*IN_WIDTH-1:0]  vec_data,
  output logic                          sample_valid,
  input  logic                          ready,
  output logic [IN_WIDTH-1:0]           sample,
  output logic [$clog2(FEATURES)-1:0]   feature_idx,
  output logic                          last,
  input  logic                          tree_done,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          err_spurious
);

  localparam int IW = $clog2(FEATURES);
  localparam logic [IW-1:0] LAST_IDX = IW'(FEATURES - 1);

  state_t                         state;
  logic [FEATURES*IN_WIDTH-1:0]   head;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           accept_en;
  logic                           push;
  logic                           pop;
  logic [IW-1:0]                  next_idx;

  // NOTE: accept_en keeps vec_ready low during reset and is derived from registers only, never from pop.
  assign vec_ready = accept_en && !fifo_full;
  assign push      = vec_valid && vec_ready;
  assign pop       = tree_done && (state != IDLE) && !fifo_empty;
  assign next_idx  = feature_idx + 1'b1;

  vector_fifo #(
    .WIDTH (FEATURES*IN_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (vec_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      accept_en    <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
      feature_idx  <= '0;
      last         <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      accept_en <= 1'b1;
      case (state)
        IDLE: begin
          if (tree_done) err_spurious <= 1'b1;
          if (occupancy != '0) begin
            state        <= STREAM;
            sample_valid <= 1'b1;
            sample       <= head[IN_WIDTH-1:0];
            feature_idx  <= '0;
            last         <= (LAST_IDX == '0);
          end
        end

        STREAM: begin
          // A result ends the vector early; a same-cycle ready is consumed but does not advance.
          if (tree_done) begin
            state        <= IDLE;
            sample_valid <= 1'b0;
            sample       <= '0;
            feature_idx  <= '0;
            last         <= 1'b0;
          end else if (ready) begin
            if (feature_idx == LAST_IDX) begin
              state        <= WAIT_DONE;
              sample_valid <= 1'b0;
              sample       <= '0;
              last         <= 1'b0;
            end else begin
              feature_idx <= next_idx;
              sample      <= head[int'(next_idx)*IN_WIDTH +: IN_WIDTH];
              last        <= (next_idx == LAST_IDX);
            end
          end
        end

        WAIT_DONE: begin
          if (tree_done) begin
            state       <= IDLE;
            feature_idx <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_streamer.sv
// Scenario bench for feature_streamer: expected samples are queued at push time
// and compared at each sample handshake.
module tb_feature_streamer;

  localparam int F = 3;
  localparam int W = 10;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           vec_valid = 1'b0;
  logic           ready = 1'b0;
  logic           tree_done = 1'b0;
  logic [F*W-1:0] vec_data = '0;
  logic           vec_ready;
  logic           sample_valid;
  logic [W-1:0]   sample;
  logic [1:0]     feature_idx;
  logic           last;
  logic [1:0]     occupancy;
  logic           err_spurious;

  typedef struct packed {
    logic [W-1:0] s;
    logic [1:0]   idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   hs_last;

  feature_streamer #(.FEATURES(F), .IN_WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .vec_data     (vec_data),
    .sample_valid (sample_valid),
    .ready        (ready),
    .sample       (sample),
    .feature_idx  (feature_idx),
    .last         (last),
    .tree_done    (tree_done),
    .occupancy    (occupancy),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic queue_vec(input logic [W-1:0] f0, input logic [W-1:0] f1, input logic [W-1:0] f2);
    exp_q.push_back('{s: f0, idx: 2'd0});
    exp_q.push_back('{s: f1, idx: 2'd1});
    exp_q.push_back('{s: f2, idx: 2'd2});
  endtask

  // Called at a negedge; the vector is accepted at the following posedge.
  task automatic push_vec(input logic [W-1:0] f0, input logic [W-1:0] f1, input logic [W-1:0] f2);
    vec_data  = {f2, f1, f0};
    vec_valid = 1'b1;
    queue_vec(f0, f1, f2);
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  // Scoreboard pop for a handshake that the next posedge will complete.
  task automatic score_hs(input string name);
    exp_t e;
    hs_last = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: handshake with nothing expected, got valid=%b sample=%h", name, sample_valid, sample);
    end else begin
      e = exp_q.pop_front();
      hs_last = (e.idx == 2'd2);
      if ({sample_valid, sample, feature_idx, last} !== {1'b1, e.s, e.idx, hs_last}) begin
        bad++;
        $display("FAIL %s: got valid=%b sample=%h idx=%0d last=%b, want valid=1 sample=%h idx=%0d last=%b",
                 name, sample_valid, sample, feature_idx, last, e.s, e.idx, hs_last);
      end
    end
  endtask

  // Streams the remaining features of the head vector with ready=1, then returns its result.
  task automatic serve(input string name);
    bit done_v = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 20 && !done_v; c++) begin
      if (sample_valid) begin
        score_hs(name);
        done_v = hs_last;
      end
      @(negedge clk);
    end
    total++;
    if (!done_v || sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: finished=%b valid=%b, want finished=1 valid=0", name, done_v, sample_valid);
    end
    ready     = 1'b0;
    tree_done = 1'b1;
    @(negedge clk);
    tree_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({vec_ready, sample_valid, sample, feature_idx, last, occupancy, err_spurious} !== '0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b v=%b s=%h idx=%0d last=%b occ=%0d err=%b, want all 0",
               vec_ready, sample_valid, sample, feature_idx, last, occupancy, err_spurious);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (vec_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: vec_ready=%b want 1", vec_ready);
    end
  endtask

  task automatic test_single();
    ready = 1'b1;
    push_vec(10'h005, 10'h3FD, 10'h1FF);
    total++;
    if (occupancy !== 2'd1 || sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_queued: occ=%0d valid=%b, want occ=1 valid=0", occupancy, sample_valid);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      score_hs("single");
      @(negedge clk);
    end
    total++;
    if (sample_valid !== 1'b0 || occupancy !== 2'd1) begin
      bad++;
      $display("FAIL single_wait: valid=%b occ=%0d, want valid=0 occ=1", sample_valid, occupancy);
    end
    tree_done = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    tree_done = 1'b0;
    total++;
    if (occupancy !== 2'd0 || sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_retire: occ=%0d valid=%b, want occ=0 valid=0", occupancy, sample_valid);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b1;
    push_vec(10'h07F, 10'h3FD, 10'h200);
    @(negedge clk);
    score_hs("bp_f0");
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sample_valid !== 1'b1 || sample !== 10'h3FD || feature_idx !== 2'd1) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d valid=%b sample=%h idx=%0d, want valid=1 sample=3fd idx=1",
                 i, sample_valid, sample, feature_idx);
      end
      @(negedge clk);
    end
    serve("bp_release");
  endtask

  task automatic test_early_leaf();
    ready = 1'b1;
    vec_data  = {10'h0A2, 10'h0A1, 10'h0A0};
    vec_valid = 1'b1;
    queue_vec(10'h0A0, 10'h0A1, 10'h0A2);
    @(negedge clk);
    vec_data = {10'h3B2, 10'h3B1, 10'h3B0};
    queue_vec(10'h3B0, 10'h3B1, 10'h3B2);
    total++;
    if (vec_ready !== 1'b1) begin
      bad++;
      $display("FAIL leaf_push_b: vec_ready=%b want 1", vec_ready);
    end
    @(negedge clk);
    vec_valid = 1'b0;
    score_hs("leaf_a0");
    @(negedge clk);
    tree_done = 1'b1;
    score_hs("leaf_a1");
    void'(exp_q.pop_front());
    @(negedge clk);
    tree_done = 1'b0;
    total++;
    if (sample_valid !== 1'b0 || feature_idx !== 2'd0 || occupancy !== 2'd1) begin
      bad++;
      $display("FAIL leaf_bubble: valid=%b idx=%0d occ=%0d, want valid=0 idx=0 occ=1",
               sample_valid, feature_idx, occupancy);
    end
    @(negedge clk);
    serve("leaf_b");
  endtask

  task automatic test_fifo_full();
    ready = 1'b0;
    vec_data  = {10'h012, 10'h011, 10'h010};
    vec_valid = 1'b1;
    queue_vec(10'h010, 10'h011, 10'h012);
    @(negedge clk);
    vec_data = {10'h122, 10'h121, 10'h120};
    queue_vec(10'h120, 10'h121, 10'h122);
    @(negedge clk);
    vec_data = {10'h232, 10'h231, 10'h230};
    total++;
    if (vec_ready !== 1'b0 || occupancy !== 2'd2) begin
      bad++;
      $display("FAIL full_refuse: vec_ready=%b occ=%0d, want vec_ready=0 occ=2", vec_ready, occupancy);
    end
    @(negedge clk);
    total++;
    if (vec_ready !== 1'b0 || occupancy !== 2'd2) begin
      bad++;
      $display("FAIL full_pop_cycle: vec_ready=%b occ=%0d, want vec_ready=0 occ=2", vec_ready, occupancy);
    end
    tree_done = 1'b1;
    repeat (3) void'(exp_q.pop_front());
    @(negedge clk);
    tree_done = 1'b0;
    total++;
    if (vec_ready !== 1'b1 || occupancy !== 2'd1) begin
      bad++;
      $display("FAIL full_after_pop: vec_ready=%b occ=%0d, want vec_ready=1 occ=1", vec_ready, occupancy);
    end
    queue_vec(10'h230, 10'h231, 10'h232);
    @(negedge clk);
    vec_valid = 1'b0;
    total++;
    if (occupancy !== 2'd2) begin
      bad++;
      $display("FAIL full_accept: occ=%0d want 2", occupancy);
    end
    serve("full_v1");
    serve("full_v2");
  endtask

  task automatic test_spurious();
    tree_done = 1'b1;
    @(negedge clk);
    tree_done = 1'b0;
    total++;
    if (err_spurious !== 1'b1 || occupancy !== 2'd0 || sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL spur_set: err=%b occ=%0d valid=%b, want err=1 occ=0 valid=0",
               err_spurious, occupancy, sample_valid);
    end
    push_vec(10'h2C0, 10'h0C1, 10'h1C2);
    serve("spur_vec");
    total++;
    if (err_spurious !== 1'b1) begin
      bad++;
      $display("FAIL spur_sticky: err=%b want 1", err_spurious);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (err_spurious !== 1'b0) begin
      bad++;
      $display("FAIL spur_clear: err=%b want 0", err_spurious);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    push_vec(10'h011, 10'h022, 10'h033);
    @(negedge clk);
    score_hs("rmid_f0");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (sample_valid !== 1'b0 || occupancy !== 2'd0 || vec_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_flush: valid=%b occ=%0d vec_ready=%b, want 0 0 0", sample_valid, occupancy, vec_ready);
    end
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    total++;
    if (vec_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_release: vec_ready=%b want 1", vec_ready);
    end
    push_vec(10'h044, 10'h155, 10'h2AA);
    serve("rmid_new");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_early_leaf();
    test_fifo_full();
    test_spurious();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: %0d samples never seen, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
